// File: rtl/mos6502_interrupt_ctrl.sv
// MOS6502 interrupt front end: NMI/SO falling-edge detection, masked IRQ level,
// and the instruction-boundary snapshot. Define IRQ_SYNC2_EN to double-sync the pins.
module mos6502_interrupt_ctrl (
   input  logic clk,
   input  logic RESET,
   input  logic nNMI,
   input  logic nIRQ,
   input  logic nSO,
   input  logic T0,
   input  logic NEXT_T,
   input  logic I_mask,
   output logic nNMI_req,
   output logic nNMI_T0,
   output logic nIRQ_req,
   output logic nIRQ_T0,
   output logic SO_req
);

   logic nmiPin;
   logic irqPin;
   logic soPin;

`ifdef IRQ_SYNC2_EN
   logic [1:0] nmiSync;
   logic [1:0] irqSync;
   logic [1:0] soSync;

   // Synchronizers idle high so leaving reset never looks like a falling edge.
   always_ff @(posedge clk) begin
      if (RESET) begin
         nmiSync <= 2'b11;
         irqSync <= 2'b11;
         soSync  <= 2'b11;
      end else begin
         nmiSync <= {nmiSync[0], nNMI};
         irqSync <= {irqSync[0], nIRQ};
         soSync  <= {soSync[0], nSO};
      end
   end

   assign nmiPin = nmiSync[1];
   assign irqPin = irqSync[1];
   assign soPin  = soSync[1];
`else
   assign nmiPin = nNMI;
   assign irqPin = nIRQ;
   assign soPin  = nSO;
`endif

   logic nmiPrev;
   logic soPrev;
   logic nmiFall;
   logic snapshot;
   logic nmiAccept;

   assign nmiFall   = nmiPrev & ~nmiPin;
   assign snapshot  = T0 & NEXT_T;
   // nNMI_req is the active-low pending flag itself.
   assign nmiAccept = snapshot & ~nNMI_req;

   // NOTE: non-blocking assignments here so every flop samples pre-edge values,
   // which is what makes the snapshot see last cycle's nNMI_req/nIRQ_req.
   always_ff @(posedge clk) begin
      if (RESET) begin
         nmiPrev  <= 1'b1;
         soPrev   <= 1'b1;
         nNMI_req <= 1'b1;
         nNMI_T0  <= 1'b1;
         nIRQ_req <= 1'b1;
         nIRQ_T0  <= 1'b1;
         SO_req   <= 1'b0;
      end else begin
         nmiPrev  <= nmiPin;
         soPrev   <= soPin;
         nIRQ_req <= irqPin | I_mask;
         SO_req   <= soPrev & ~soPin;

         // A new edge in the accepting cycle wins so no NMI is ever dropped.
         if (nmiFall)
            nNMI_req <= 1'b0;
         else if (nmiAccept)
            nNMI_req <= 1'b1;

         if (snapshot) begin
            nNMI_T0 <= nNMI_req;
            nIRQ_T0 <= nIRQ_req | ~nNMI_req;
         end
      end
   end

endmodule

// File: tb/tb_mos6502_interrupt_ctrl.sv
// Directed bench for mos6502_interrupt_ctrl; pin latencies track IRQ_SYNC2_EN.
module tb_mos6502_interrupt_ctrl;

`ifdef IRQ_SYNC2_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif

   logic clk = 1'b0;
   logic RESET, nNMI, nIRQ, nSO, T0, NEXT_T, I_mask;
   logic nNMI_req, nNMI_T0, nIRQ_req, nIRQ_T0, SO_req;

   int nvec = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   mos6502_interrupt_ctrl dut (
      .clk(clk), .RESET(RESET), .nNMI(nNMI), .nIRQ(nIRQ), .nSO(nSO),
      .T0(T0), .NEXT_T(NEXT_T), .I_mask(I_mask),
      .nNMI_req(nNMI_req), .nNMI_T0(nNMI_T0), .nIRQ_req(nIRQ_req),
      .nIRQ_T0(nIRQ_T0), .SO_req(SO_req)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1; nNMI = 1'b1; nIRQ = 1'b1; nSO = 1'b1;
      T0 = 1'b0; NEXT_T = 1'b0; I_mask = 1'b0;
      tick(3);
      nvec++; if (nNMI_req !== 1'b1) begin nfail++; $display("FAIL reset_nNMI_req: got %b want 1", nNMI_req); end
      nvec++; if (nNMI_T0 !== 1'b1) begin nfail++; $display("FAIL reset_nNMI_T0: got %b want 1", nNMI_T0); end
      nvec++; if (nIRQ_req !== 1'b1) begin nfail++; $display("FAIL reset_nIRQ_req: got %b want 1", nIRQ_req); end
      nvec++; if (nIRQ_T0 !== 1'b1) begin nfail++; $display("FAIL reset_nIRQ_T0: got %b want 1", nIRQ_T0); end
      nvec++; if (SO_req !== 1'b0) begin nfail++; $display("FAIL reset_SO_req: got %b want 0", SO_req); end
      RESET = 1'b0;
      tick(2);
      nvec++; if (nNMI_req !== 1'b1) begin nfail++; $display("FAIL reset_no_false_edge: got %b want 1", nNMI_req); end
   endtask

   task automatic test_irq();
      nIRQ = 1'b0; I_mask = 1'b0;
      tick(1 + S);
      nvec++; if (nIRQ_req !== 1'b0) begin nfail++; $display("FAIL irq_req_low: got %b want 0", nIRQ_req); end
      nvec++; if (nIRQ_T0 !== 1'b1) begin nfail++; $display("FAIL irq_T0_before_snap: got %b want 1", nIRQ_T0); end
      T0 = 1'b1; NEXT_T = 1'b1;
      tick(1);
      nvec++; if (nIRQ_T0 !== 1'b0) begin nfail++; $display("FAIL irq_T0_snap: got %b want 0", nIRQ_T0); end
      nvec++; if (nNMI_T0 !== 1'b1) begin nfail++; $display("FAIL irq_nmi_T0_idle: got %b want 1", nNMI_T0); end
      T0 = 1'b0; I_mask = 1'b1;
      tick(1);
      nvec++; if (nIRQ_req !== 1'b1) begin nfail++; $display("FAIL irq_masked: got %b want 1", nIRQ_req); end
      nvec++; if (nIRQ_T0 !== 1'b0) begin nfail++; $display("FAIL irq_T0_hold: got %b want 0", nIRQ_T0); end
      T0 = 1'b1;
      tick(1);
      nvec++; if (nIRQ_T0 !== 1'b1) begin nfail++; $display("FAIL irq_T0_masked_snap: got %b want 1", nIRQ_T0); end
      T0 = 1'b0; NEXT_T = 1'b0; nIRQ = 1'b1; I_mask = 1'b0;
      tick(1 + S);
   endtask

   task automatic test_nmi_held();
      T0 = 1'b1; NEXT_T = 1'b0; nNMI = 1'b0;
      tick(1 + S);
      nvec++; if (nNMI_req !== 1'b0) begin nfail++; $display("FAIL nmi_req_low: got %b want 0", nNMI_req); end
      for (int i = 0; i < 11; i++) begin
         tick(1);
         nvec++; if (nNMI_req !== 1'b0 || nNMI_T0 !== 1'b1) begin
            nfail++; $display("FAIL nmi_pending_hold[%0d]: got req=%b T0=%b want req=0 T0=1", i, nNMI_req, nNMI_T0);
         end
      end
      NEXT_T = 1'b1;
      tick(1);
      nvec++; if (nNMI_T0 !== 1'b0) begin nfail++; $display("FAIL nmi_T0_accept: got %b want 0", nNMI_T0); end
      nvec++; if (nNMI_req !== 1'b1) begin nfail++; $display("FAIL nmi_req_cleared: got %b want 1", nNMI_req); end
      nvec++; if (nIRQ_T0 !== 1'b1) begin nfail++; $display("FAIL nmi_irq_T0_high: got %b want 1", nIRQ_T0); end
      NEXT_T = 1'b0;
      tick(5);
      nvec++; if (nNMI_req !== 1'b1) begin nfail++; $display("FAIL nmi_no_rerequest: got %b want 1", nNMI_req); end
      nNMI = 1'b1; T0 = 1'b0;
      tick(1 + S);
   endtask

   task automatic test_nmi_pulse();
      T0 = 1'b0; NEXT_T = 1'b1; nNMI = 1'b0;
      tick(1);
      nNMI = 1'b1;
      tick(S);
      nvec++; if (nNMI_req !== 1'b0) begin nfail++; $display("FAIL pulse_caught: got %b want 0", nNMI_req); end
      tick(4);
      nvec++; if (nNMI_req !== 1'b0) begin nfail++; $display("FAIL pulse_held: got %b want 0", nNMI_req); end
      nvec++; if (nNMI_T0 !== 1'b0) begin nfail++; $display("FAIL pulse_T0_hold: got %b want 0", nNMI_T0); end
      T0 = 1'b1;
      tick(1);
      nvec++; if (nNMI_T0 !== 1'b0 || nNMI_req !== 1'b1) begin
         nfail++; $display("FAIL pulse_accept: got T0=%b req=%b want T0=0 req=1", nNMI_T0, nNMI_req);
      end
      tick(1);
      nvec++; if (nNMI_T0 !== 1'b1) begin nfail++; $display("FAIL pulse_next_snap: got %b want 1", nNMI_T0); end
      T0 = 1'b0;
   endtask

   task automatic test_priority();
      T0 = 1'b0; NEXT_T = 1'b1; nIRQ = 1'b0; I_mask = 1'b0; nNMI = 1'b0;
      tick(1 + S);
      nvec++; if (nNMI_req !== 1'b0 || nIRQ_req !== 1'b0) begin
         nfail++; $display("FAIL prio_reqs: got nmi=%b irq=%b want 0 0", nNMI_req, nIRQ_req);
      end
      T0 = 1'b1;
      tick(1);
      nvec++; if (nNMI_T0 !== 1'b0 || nIRQ_T0 !== 1'b1) begin
         nfail++; $display("FAIL prio_nmi_first: got nmi_T0=%b irq_T0=%b want 0 1", nNMI_T0, nIRQ_T0);
      end
      tick(1);
      nvec++; if (nNMI_T0 !== 1'b1 || nIRQ_T0 !== 1'b0) begin
         nfail++; $display("FAIL prio_irq_next: got nmi_T0=%b irq_T0=%b want 1 0", nNMI_T0, nIRQ_T0);
      end
      T0 = 1'b0; nNMI = 1'b1; nIRQ = 1'b1;
      tick(1 + S);
   endtask

   task automatic test_so();
      nSO = 1'b0;
      tick(1 + S);
      nvec++; if (SO_req !== 1'b1) begin nfail++; $display("FAIL so_pulse: got %b want 1", SO_req); end
      for (int i = 0; i < 4; i++) begin
         tick(1);
         nvec++; if (SO_req !== 1'b0) begin nfail++; $display("FAIL so_single[%0d]: got %b want 0", i, SO_req); end
      end
      nSO = 1'b1;
      tick(1 + S);
      nvec++; if (SO_req !== 1'b0) begin nfail++; $display("FAIL so_rise: got %b want 0", SO_req); end
   endtask

   task automatic test_back_to_back();
      T0 = 1'b0; NEXT_T = 1'b1; nNMI = 1'b0;
      tick(1);
      nNMI = 1'b1;
      tick(2 + S);
      nvec++; if (nNMI_req !== 1'b0) begin nfail++; $display("FAIL b2b_pending: got %b want 0", nNMI_req); end
      nNMI = 1'b0;
      tick(S);
      T0 = 1'b1;
      tick(1);
      nvec++; if (nNMI_T0 !== 1'b0 || nNMI_req !== 1'b0) begin
         nfail++; $display("FAIL b2b_set_wins: got T0=%b req=%b want 0 0", nNMI_T0, nNMI_req);
      end
      tick(1);
      nvec++; if (nNMI_req !== 1'b1 || nNMI_T0 !== 1'b0) begin
         nfail++; $display("FAIL b2b_second_accept: got req=%b T0=%b want 1 0", nNMI_req, nNMI_T0);
      end
      T0 = 1'b0; nNMI = 1'b1;
      tick(1 + S);
   endtask

   task automatic test_random_exclusive();
      for (int i = 0; i < 300; i++) begin
         nNMI = 1'($urandom); nIRQ = 1'($urandom); nSO = 1'($urandom);
         T0 = 1'($urandom); NEXT_T = 1'($urandom); I_mask = 1'($urandom);
         tick(1);
         nvec++; if (nNMI_T0 === 1'b0 && nIRQ_T0 === 1'b0) begin
            nfail++; $display("FAIL rand_exclusive[%0d]: got nmi_T0=0 irq_T0=0 want not both 0", i);
         end
      end
      nNMI = 1'b1; nIRQ = 1'b1; nSO = 1'b1; T0 = 1'b0; NEXT_T = 1'b0; I_mask = 1'b0;
      tick(3 + S);
   endtask

   task automatic test_reset_mid();
      nNMI = 1'b0;
      tick(1);
      nNMI = 1'b1;
      tick(1 + S);
      nvec++; if (nNMI_req !== 1'b0) begin nfail++; $display("FAIL rmid_pending: got %b want 0", nNMI_req); end
      RESET = 1'b1;
      tick(1);
      nvec++; if (nNMI_req !== 1'b1 || nNMI_T0 !== 1'b1 || nIRQ_T0 !== 1'b1 || nIRQ_req !== 1'b1 || SO_req !== 1'b0) begin
         nfail++; $display("FAIL rmid_outputs: got %b%b%b%b%b want 11110", nNMI_req, nNMI_T0, nIRQ_req, nIRQ_T0, SO_req);
      end
      RESET = 1'b0;
      tick(4);
      nvec++; if (nNMI_req !== 1'b1) begin nfail++; $display("FAIL rmid_discarded: got %b want 1", nNMI_req); end
   endtask

   initial begin
      test_reset();
      test_irq();
      test_nmi_held();
      test_nmi_pulse();
      test_priority();
      test_so();
      test_back_to_back();
      test_random_exclusive();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
